// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results to writeback in 1 cycle, runs one req/ack bus transaction per memory op.
// Stalls upstream from the accept cycle until ack or timeout; ack combinationally releases stall.
module mem_stage #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_out,
  input  logic [3:0]        i_dst,
  input  logic              i_mem_en,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_st_data,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_fault,
  output logic [DATA_W-1:0] wb_out,
  output logic [3:0]        wb_dst_reg,
  output logic              wb_en
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] counter;
  logic [3:0]       dst_q;
  logic             timeout_hit;

  // A zero TIMEOUT disables the abort entirely.
  assign timeout_hit = (TIMEOUT != 0) && (counter == CNT_LAST);

  always_comb begin
    if (state == ST_IDLE) begin
      stall = i_mem_en;
    end else begin
      stall = ~bus_ack & ~timeout_hit;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state      <= ST_IDLE;
      counter    <= '0;
      dst_q      <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_fault  <= 1'b0;
      wb_out     <= '0;
      wb_dst_reg <= '0;
      wb_en      <= 1'b0;
    end else begin
      bus_fault <= 1'b0;
      if (state == ST_IDLE) begin
        if (i_mem_en) begin
          bus_addr  <= i_mem_addr;
          bus_we    <= i_mem_write;
          bus_wdata <= i_st_data;
          dst_q     <= i_dst;
          bus_req   <= 1'b1;
          counter   <= '0;
          wb_en     <= 1'b0;
          state     <= ST_BUSY;
        end else begin
          wb_out     <= i_out;
          wb_dst_reg <= i_dst;
          wb_en      <= i_en;
        end
      end else begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack) begin
          bus_req <= 1'b0;
          state   <= ST_IDLE;
          if (!bus_we) begin
            wb_out     <= bus_rdata;
            wb_dst_reg <= dst_q;
            wb_en      <= 1'b1;
          end else begin
            wb_en <= 1'b0;
          end
        end else if (timeout_hit) begin
          bus_req   <= 1'b0;
          bus_fault <= 1'b1;
          wb_en     <= 1'b0;
          state     <= ST_IDLE;
        end else begin
          wb_en <= 1'b0;
          if (counter != CNT_MAX) begin
            counter <= counter + 1'b1;
          end
        end
      end
    end
  end

endmodule
